// File: rtl/pds_det_seq.sv
// pds_det_seq: detection sequencer in front of the power delivery controller.
// It picks the eligible port with the highest priority, drives a one-hot
// probe for DET_CYCLES clocks, samples the sense result, and latches det.
// After each successful detection it waits in HOLD so that det rising
// edges, and the port turn-ons that follow them, are serialized.
// Optional feature: define PDS_DET_SEQ_RETRY_LIMIT_EN to flag a port in
// fault after three consecutive failed probes and stop probing it until
// its req drops.
module pds_det_seq #(
  parameter int NUM_PORTS      = 4,
  parameter int DET_CYCLES     = 8,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [2*NUM_PORTS-1:0] prio,
  input  logic [NUM_PORTS-1:0]   sense,
  input  logic                   ports_off,
  output logic [NUM_PORTS-1:0]   probe,
  output logic [NUM_PORTS-1:0]   det,
  output logic                   busy,
  output logic [NUM_PORTS-1:0]   fault
);

  localparam int MAX_CYCLES = (DET_CYCLES > STAGGER_CYCLES) ? DET_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam int PTR_W      = $clog2(NUM_PORTS);

  localparam logic [CNT_W-1:0] DET_LOAD  = CNT_W'(DET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]  probe_d;
  logic [NUM_PORTS-1:0]  det_d;
  logic [NUM_PORTS-1:0]  fault_d;
  logic                  busy_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic                  sel_valid;
  logic [PTR_W-1:0]      sel_ptr;
  logic [1:0]            sel_prio;

  assign eligible = req & ~det & ~fault;

  // Priority pick: highest prio wins, strict compare keeps the lowest index on ties.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    sel_valid = 1'b0;
    sel_ptr   = '0;
    sel_prio  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && (!sel_valid || (prio[2*i +: 2] > sel_prio))) begin
        sel_valid = 1'b1;
        sel_ptr   = PTR_W'(i);
        sel_prio  = prio[2*i +: 2];
      end
    end
  end

  // Sequencer next-state, counter, pointer, probe and det update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    probe_d = probe;
    // A dropped request clears its det bit on the next clock in any state.
    det_d   = det & req;

    if (ports_off) begin
      state_d = IDLE;
      cnt_d   = '0;
      probe_d = '0;
      det_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            ptr_d          = sel_ptr;
            cnt_d          = DET_LOAD;
            probe_d        = '0;
            probe_d[sel_ptr] = 1'b1;
            state_d        = PROBE;
          end
        end
        PROBE: begin
          if (!req[ptr_q]) begin
            // Requester went away mid-probe: abandon without touching det.
            probe_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            probe_d = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SAMPLE: begin
          probe_d = '0;
          if (!req[ptr_q]) begin
            state_d = IDLE;
          end else if (sense[ptr_q]) begin
            det_d[ptr_q] = 1'b1;
            cnt_d        = STAG_LOAD;
            state_d      = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          probe_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

`ifdef PDS_DET_SEQ_RETRY_LIMIT_EN
  logic [NUM_PORTS-1:0][1:0] fail_q, fail_d;
  logic                      sample_live;

  // A sample counts only when it is neither overridden by ports_off nor aborted by a req drop.
  assign sample_live = (state_q == SAMPLE) && !ports_off && req[ptr_q];

  // Consecutive-failure tracking and fault flagging per port.
  always_comb begin
    fail_d  = fail_q;
    fault_d = fault;
    if (sample_live) begin
      if (sense[ptr_q]) begin
        fail_d[ptr_q] = 2'd0;
      end else begin
        fail_d[ptr_q] = fail_q[ptr_q] + 2'd1;
        if (fail_q[ptr_q] == 2'd2) begin
          fault_d[ptr_q] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req[i]) begin
        fail_d[i]  = 2'd0;
        fault_d[i] = 1'b0;
      end
    end
  end

  // Failure counters; the array is small, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this counter array is explicitly reset; a port must never start
      // with a stale failure count that could fault it early.
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end
`else
  // Without the retry limit a failed port is simply retried forever.
  always_comb begin
    fault_d = '0;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      probe   <= '0;
      det     <= '0;
      busy    <= 1'b0;
      fault   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      probe   <= probe_d;
      det     <= det_d;
      busy    <= busy_d;
      fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_pds_det_seq.sv
// tb_pds_det_seq: directed, self-checking bench for pds_det_seq with
// default parameters (4 ports, 8-clock probe, 16-clock stagger).
// Expectations adapt when PDS_DET_SEQ_RETRY_LIMIT_EN is defined.
module tb_pds_det_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] prio;
  logic [3:0] sense;
  logic       ports_off;
  logic [3:0] probe;
  logic [3:0] det;
  logic       busy;
  logic [3:0] fault;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pds_det_seq #(
    .NUM_PORTS     (4),
    .DET_CYCLES    (8),
    .STAGGER_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .prio     (prio),
    .sense    (sense),
    .ports_off(ports_off),
    .probe    (probe),
    .det      (det),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("probe_onehot", {31'd0, $onehot0(probe)}, 32'd1);
  endtask

  initial begin
    int  high_cnt;
    int  busy_cnt;
    int  t_det3;
    int  t_det1;
    int  rises;
    int  max_det;
    logic prev_p2;
    logic found;

    rst_n     = 1'b0;
    req       = '0;
    prio      = '0;
    sense     = '0;
    ports_off = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_probe", {28'd0, probe}, 32'h0);
    check("rst_det",   {28'd0, det},   32'h0);
    check("rst_busy",  {31'd0, busy},  32'h0);
    check("rst_fault", {28'd0, fault}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'h0);

    // ---------------- single port detect ----------------
    req   = 4'b0001;
    sense = 4'b0001;
    tick();
    check("t1_probe_start", {28'd0, probe}, 32'h1);
    check("t1_busy", {31'd0, busy}, 32'h1);
    high_cnt = 1;
    for (int i = 0; i < 20 && probe == 4'b0001; i++) begin
      tick();
      if (probe == 4'b0001) high_cnt++;
    end
    check("t1_probe_width", high_cnt, 8);
    check("t1_det_in_sample", {28'd0, det}, 32'h0);
    tick();
    check("t1_det_set", {28'd0, det}, 32'h1);
    busy_cnt = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      busy_cnt++;
      tick();
    end
    check("t1_hold_len", busy_cnt, 16);
    check("t1_idle_probe", {28'd0, probe}, 32'h0);

    // ---------------- priority pick and stagger ----------------
    req = 4'b0000;
    tick();
    check("t2_det_cleared", {28'd0, det}, 32'h0);
    req   = 4'b1010;
    prio  = 8'b11_00_01_00;
    sense = 4'b1010;
    tick();
    check("t2_first_probe", {28'd0, probe}, 32'h8);
    t_det3 = -1;
    t_det1 = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (det[3] && t_det3 < 0) t_det3 = cyc;
      if (det[1] && t_det1 < 0) t_det1 = cyc;
    end
    check("t2_det_final", {28'd0, det}, 32'ha);
    check("t2_order", {31'd0, (t_det3 >= 0) && (t_det1 > t_det3)}, 32'h1);
    check("t2_spacing_min", {31'd0, (t_det1 - t_det3) >= 18}, 32'h1);
    check("t2_spacing", t_det1 - t_det3, 26);

    // ---------------- repeated failing probe ----------------
    req   = 4'b0000;
    prio  = 8'h00;
    sense = 4'b0000;
    tick();
    req     = 4'b0100;
    prev_p2 = 1'b0;
    rises   = 0;
    max_det = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (probe[2] && !prev_p2) rises++;
      prev_p2 = probe[2];
      if (det != 4'b0000) max_det = 1;
    end
    check("t3_det_zero", max_det, 0);
`ifdef PDS_DET_SEQ_RETRY_LIMIT_EN
    check("t3_probe_count", rises, 3);
    check("t3_fault", {28'd0, fault}, 32'h4);
    check("t3_idle", {31'd0, busy}, 32'h0);
`else
    check("t3_probe_count", rises, 6);
    check("t3_fault", {28'd0, fault}, 32'h0);
`endif
    req = 4'b0000;
    tick();
    check("t3_fault_clear", {28'd0, fault}, 32'h0);

    // ---------------- abort on req drop ----------------
    req   = 4'b0001;
    sense = 4'b0001;
    tick();
    check("t4_probe", {28'd0, probe}, 32'h1);
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    check("t4_abort_probe", {28'd0, probe}, 32'h0);
    check("t4_abort_busy", {31'd0, busy}, 32'h0);
    check("t4_abort_det", {28'd0, det}, 32'h0);

    // ---------------- ports_off ----------------
    req   = 4'b0011;
    sense = 4'b0011;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (det == 4'b0011) found = 1'b1;
    end
    check("t5_det_both", {31'd0, found}, 32'h1);
    ports_off = 1'b1;
    tick();
    check("t5_off_det", {28'd0, det}, 32'h0);
    check("t5_off_probe", {28'd0, probe}, 32'h0);
    check("t5_off_busy", {31'd0, busy}, 32'h0);
    ports_off = 1'b0;
    tick();
    check("t5_redetect", {28'd0, probe}, 32'h1);

    // ---------------- async reset mid-HOLD ----------------
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (det == 4'b0001) found = 1'b1;
    end
    check("t6_det0", {31'd0, found}, 32'h1);
    tick();
    tick();
    tick();
    check("t6_in_hold", {31'd0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_probe", {28'd0, probe}, 32'h0);
    check("t6_async_det",   {28'd0, det},   32'h0);
    check("t6_async_busy",  {31'd0, busy},  32'h0);
    check("t6_async_fault", {28'd0, fault}, 32'h0);
    tick();
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    check("t6_post_busy", {31'd0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pds_det_seq.md
Name: pds_det_seq

Overview:
- Detection sequencer that sits in front of the power delivery controller. It decides which port is probed for a valid powered device, drives the probe, and samples the sense result.
- Publishes a latched per-port det vector that the controller consumes when granting power.
- New det bits are spaced by a stagger hold, so port turn-ons (and inrush) are naturally serialized.

Parameters:
- NUM_PORTS, 4, number of ports (2..16).
- DET_CYCLES, 8, probe duration in clocks (>=2).
- STAGGER_CYCLES, 16, minimum clocks between successive det rising edges (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_PORTS, port i requests power service.
- prio, input, 2*NUM_PORTS, 2-bit priority per port; bits [2i+1:2i] belong to port i; 3 is highest.
- sense, input, NUM_PORTS, analog-front-end detect result; only sense[ptr] is meaningful during SAMPLE.
- ports_off, input, 1, global shutdown.
- probe, output, NUM_PORTS, one-hot probe drive.
- det, output, NUM_PORTS, latched detection status to the controller.
- busy, output, 1, FSM not in IDLE.
- fault, output, NUM_PORTS, per-port retry-exhausted flag (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - probe=0, det=0, fault=0, busy=0.
  - state=IDLE, counters=0, ptr=0.
- All outputs are registered.
- Eligible port i: req[i]=1 & det[i]=0 & fault[i]=0.
- Selection:
  - Pick the eligible port with the highest prio.
  - Ties go to the lowest index.
  - Selection is combinational from current inputs and is latched into ptr on the IDLE->PROBE transition.
- FSM states: IDLE, PROBE, SAMPLE, HOLD.
  - IDLE: if any port is eligible and ports_off=0, then latch ptr, load cnt=DET_CYCLES-1, go to PROBE. probe[ptr]=1 is visible from the next cycle.
  - PROBE: probe[ptr]=1. Decrement cnt each cycle. At cnt==0, go to SAMPLE. Probe pulse width is exactly DET_CYCLES clocks.
  - SAMPLE (1 cycle): probe=0.
    - If sense[ptr]=1: det[ptr]<=1, load cnt=STAGGER_CYCLES-1, go to HOLD.
    - Else: go to IDLE. det is unchanged.
  - HOLD: decrement cnt; at 0 go to IDLE. No probing in HOLD. This guarantees the det rising-edge spacing is >= STAGGER_CYCLES+2 clocks.
- req[i] falling:
  - det[i] clears on the next clock, in any state.
  - If i==ptr during PROBE or SAMPLE: abort, probe=0, go to IDLE next cycle, det[ptr] not set.
  - HOLD is not aborted.
- ports_off=1 (highest priority, sampled each clock):
  - det<=0, probe<=0, state<=IDLE, cnt<=0.
  - Sequencer stays in IDLE while ports_off remains 1.
  - fault is not cleared.
- Simultaneous events in SAMPLE:
  - ports_off overrides sense.
  - A req[ptr] drop overrides sense=1; det is not set.
- Priority or req changes during PROBE do not change ptr.
- Counter width: $clog2(max(DET_CYCLES,STAGGER_CYCLES))+1; no wrap is possible.
- Only one probe bit is ever high at a time.

Optional Feature:
- Macro PDS_DET_SEQ_RETRY_LIMIT_EN.
- When defined:
  - A per-port 2-bit consecutive-failure counter increments on each SAMPLE with sense=0.
  - The counter clears on SAMPLE with sense=1 or when req[i]=0.
  - When the counter reaches 3, fault[i]<=1 and the port becomes ineligible.
  - fault[i] clears only when req[i]=0 or on reset.
- When not defined: fault is tied to 0 and failed ports are retried indefinitely.

Test Plan:
- Reset, then req=4'b0001, sense=4'b0001 -> probe[0] high for exactly 8 clocks; det=4'b0001 one clock after probe falls; busy stays high for 16 more clocks.
- req=4'b1010, prio port3=3, port1=1, sense=4'b1010 -> port 3 probed first; det[3] and det[1] rising edges separated by >=18 clocks.
- req=4'b0100, sense=0 -> repeated 8-clock probes on port 2; det stays 0. With PDS_DET_SEQ_RETRY_LIMIT_EN, fault[2]=1 after the 3rd failure, no 4th probe; fault clears when req[2] drops.
- Drop req[0] at cycle 4 of probe on port 0 -> probe=0 next clock, FSM returns to IDLE, det[0]=0.
- With det=4'b0011, assert ports_off for 1 clock -> det=0, probe=0, busy=0 next clock; re-detection starts after ports_off deasserts.
- Assert rst_n low mid-HOLD -> all outputs 0 immediately (asynchronous).
